ro_puf_challenger: RTL
======================

RO_PUF_CHALLENGER -- requirements
Module: ro_puf_challenger

Interface
REQ-001 SHALL have parameter NUM_CHAL, default 4, number of 2-bit challenges per request (1..8).
REQ-002 SHALL have parameter RST_CYCLES, default 2, cycles puf_reset is held per challenge (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum RUN cycles per challenge (only used with PUF_CHAL_TIMEOUT_EN).
REQ-004 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  request pulse; sampled only in IDLE.
REQ-008 challenge  input  2*NUM_CHAL  challenge vector; element i = challenge[2i+1:2i], issued i=0 first.
REQ-009 count1, count2  input  4 each  PUF edge counters; asynchronous to clk.
REQ-010 puf_en, puf_reset  output  1 each  drive PUF enable and counter clear.
REQ-011 puf_sel  output  2  drives PUF oscillator-pair select S.
REQ-012 busy, done  output  1 each  busy = not IDLE; done = one-cycle completion pulse.
REQ-013 response  output  NUM_CHAL  bit i = result of challenge i.
REQ-014 tie_flags, to_flags  output  NUM_CHAL each  per-challenge equal-count and timeout markers.

Function
REQ-015 SHALL implement FSM IDLE -> CLR -> RUN -> SETTLE -> CAPTURE -> NEXT -> (CLR | DONE) -> IDLE, all outputs registered.
REQ-016 IDLE with start=1: latch challenge, idx=0, clear response/tie_flags/to_flags, enter CLR next cycle; start=0: stay.
REQ-017 start while busy=1 SHALL be ignored; challenge changes after latch SHALL have no effect.
REQ-018 CLR: puf_reset=1, puf_en=0, puf_sel=latched element idx, exactly RST_CYCLES cycles, then RUN.
REQ-019 puf_sel SHALL be stable from CLR entry through CAPTURE for each challenge.
REQ-020 RUN: puf_reset=0, puf_en=1; sat = (&count1)|(&count2) passed through a 2-FF synchronizer; synchronized sat=1 -> SETTLE.
REQ-021 SETTLE: puf_en=0 for 2 cycles, then CAPTURE; multi-bit counts SHALL only be sampled in CAPTURE.
REQ-022 CAPTURE (1 cycle): response[idx] = (count1 > count2); tie_flags[idx] = (count1 == count2), response bit 0 on tie.
REQ-023 NEXT: idx==NUM_CHAL-1 -> DONE, else idx+1 -> CLR.
REQ-024 DONE: done=1 for one cycle, -> IDLE; response/flags held until next accepted start.
REQ-025 Per-challenge latency without timeout: RST_CYCLES + (RUN cycles) + 2 + 1 + 1 cycles.
REQ-026 Synchronizer SHALL be cleared on CLR entry so stale saturation from a prior challenge cannot end RUN.

Reset
REQ-027 reset=1 at any clock edge SHALL force IDLE from any state, including mid-RUN.
REQ-028 Reset values: puf_en=0, puf_reset=1, puf_sel=0, busy=0, done=0, response=0, tie_flags=0, to_flags=0, idx=0, synchronizer=0.
REQ-029 First IDLE cycle after reset deasserts SHALL drive puf_reset=0.

Configuration
REQ-030 Macro PUF_CHAL_TIMEOUT_EN defined: RUN counts cycles; at TIMEOUT cycles without synchronized sat, set to_flags[idx]=1, response[idx]=0, puf_en=0, go NEXT (skip SETTLE/CAPTURE).
REQ-031 Macro undefined: no timeout counter, RUN waits indefinitely, to_flags tied to 0.

Verification
REQ-032 NUM_CHAL=4, challenge=8'b11_10_01_00, PUF model count1 saturates first each time -> puf_sel sequence 0,1,2,3; response=4'b1111; done one pulse; tie_flags=0.
REQ-033 Model count2 faster on challenges 1,3 -> response=4'b0101.
REQ-034 Model ends challenge 2 with count1=count2=15 -> tie_flags=4'b0100, response[2]=0.
REQ-035 reset asserted in RUN of challenge 1 -> next cycle IDLE, puf_en=0, puf_reset=1, busy=0, done never pulses; subsequent start completes normally.
REQ-036 start pulsed during RUN with different challenge -> ignored; response matches originally latched challenge.
REQ-037 PUF_CHAL_TIMEOUT_EN, TIMEOUT=20, model never saturates on challenge 0 -> after 20 RUN cycles to_flags=4'b0001, response[0]=0, sequence continues to done.

Source files
------------

// File: rtl/ro_puf_challenger.sv
// Ring-oscillator PUF challenge sequencer: issues each 2-bit challenge, races the two
// edge counters to saturation, and records the winner. Optional timeout: PUF_CHAL_TIMEOUT_EN.
module ro_puf_challenger #(
    parameter int unsigned NUM_CHAL   = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*NUM_CHAL-1:0] challenge,
    input  logic [3:0]            count1,
    input  logic [3:0]            count2,
    output logic                  puf_en,
    output logic                  puf_reset,
    output logic [1:0]            puf_sel,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CHAL-1:0]   response,
    output logic [NUM_CHAL-1:0]   tie_flags,
    output logic [NUM_CHAL-1:0]   to_flags
);

    localparam int unsigned IDX_W   = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
    localparam int unsigned CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_SETTLE, S_CAPTURE, S_NEXT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*NUM_CHAL-1:0]  chal_q, chal_d;
    logic                   sync1_q, sync2_q;
    logic                   sat_c;

    logic                   puf_en_q, puf_en_d;
    logic                   puf_reset_q, puf_reset_d;
    logic [1:0]             puf_sel_q, puf_sel_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_CHAL-1:0]    resp_q, resp_d;
    logic [NUM_CHAL-1:0]    tie_q, tie_d;

    assign sat_c = (&count1) | (&count2);

    // State and sequencing registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            chal_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            chal_q  <= chal_d;
        end
    end

    // Saturation synchronizer; held clear in CLR so a previous race cannot leak through
    always_ff @(posedge clk) begin
        if (reset || state_d == S_CLR) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sat_c;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        chal_d  = chal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (sync2_q) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
`ifdef PUF_CHAL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: state_d = S_NEXT;
            S_NEXT: begin
                cnt_d = '0;
                if (idx_q == IDX_W'(NUM_CHAL - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_CLR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PUF_CHAL_TIMEOUT_EN
    logic [NUM_CHAL-1:0] to_q, to_d;
    logic                tmo_c;
    assign tmo_c = (state_q == S_RUN) && !sync2_q && (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // Next values of the registered outputs, aligned with the state being entered
    always_comb begin
        puf_en_d    = (state_d == S_RUN);
        puf_reset_d = (state_d == S_CLR);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        puf_sel_d   = puf_sel_q;
        resp_d      = resp_q;
        tie_d       = tie_q;
`ifdef PUF_CHAL_TIMEOUT_EN
        to_d        = to_q;
`endif
        if (state_q == S_IDLE && start) begin
            resp_d = '0;
            tie_d  = '0;
`ifdef PUF_CHAL_TIMEOUT_EN
            to_d   = '0;
`endif
        end
        if (state_d == S_CLR && state_q != S_CLR) begin
            for (int i = 0; i < NUM_CHAL; i++) begin
                if (idx_d == IDX_W'(i)) puf_sel_d = chal_d[2*i +: 2];
            end
        end
        if (state_q == S_CAPTURE) begin
            for (int i = 0; i < NUM_CHAL; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    resp_d[i] = (count1 > count2);
                    tie_d[i]  = (count1 == count2);
                end
            end
        end
`ifdef PUF_CHAL_TIMEOUT_EN
        if (tmo_c) begin
            for (int i = 0; i < NUM_CHAL; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    to_d[i]   = 1'b1;
                    resp_d[i] = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            puf_en_q    <= 1'b0;
            puf_reset_q <= 1'b1;
            puf_sel_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resp_q      <= '0;
            tie_q       <= '0;
`ifdef PUF_CHAL_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            puf_en_q    <= puf_en_d;
            puf_reset_q <= puf_reset_d;
            puf_sel_q   <= puf_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
            tie_q       <= tie_d;
`ifdef PUF_CHAL_TIMEOUT_EN
            to_q        <= to_d;
`endif
        end
    end

    assign puf_en    = puf_en_q;
    assign puf_reset = puf_reset_q;
    assign puf_sel   = puf_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;
    assign tie_flags = tie_q;
`ifdef PUF_CHAL_TIMEOUT_EN
    assign to_flags  = to_q;
`else
    assign to_flags  = '0;
`endif

endmodule
